// File: rtl/mvm_stream_core.sv
// mvm_stream_core
// Streaming matrix-vector multiply engine sitting between a UART RX byte
// stream and a UART TX byte stream.
//
// Command bytes (accepted in IDLE):
//   0x01 LOAD_M : next N_ROWS*N_COLS bytes are the matrix, row-major.
//   0x02 LOAD_V : next N_COLS bytes are the vector; the multiply then runs and
//                 every row result is returned as OUT_BYTES bytes, LSB first.
//   0x03 CLEAR  : zero the matrix and the sticky error flag.
//   other       : set the sticky error flag.
// The matrix persists across runs. Elements are the low DATA_W bits of each
// byte, interpreted as signed. Results wrap modulo 2^(OUT_BYTES*8).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_valid/s_ready   input byte stream
//   m_data/m_valid/m_ready   output byte stream
//   busy              high whenever the engine is not in IDLE
//   err               sticky unknown-command flag
//
// Handshake: a byte moves on a port in any cycle where valid and ready are
// both high at the rising clock edge. s_ready, m_valid and m_data are all
// registered; m_valid/m_data hold their value until the byte is taken and
// never depend combinationally on m_ready.
module mvm_stream_core #(
  parameter int N_ROWS    = 4,
  parameter int N_COLS    = 4,
  parameter int DATA_W    = 8,
  parameter int OUT_BYTES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       err
);

  localparam int N_ELEM = N_ROWS * N_COLS;
  localparam int ACC_W  = OUT_BYTES * 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int EL_W   = (N_ELEM > 1)    ? $clog2(N_ELEM)    : 1;
  localparam int ROW_W  = (N_ROWS > 1)    ? $clog2(N_ROWS)    : 1;
  localparam int COL_W  = (N_COLS > 1)    ? $clog2(N_COLS)    : 1;
  localparam int BYTE_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  localparam logic [7:0] CMD_LOAD_M = 8'h01;
  localparam logic [7:0] CMD_LOAD_V = 8'h02;
  localparam logic [7:0] CMD_CLEAR  = 8'h03;

  // S_START is the one-cycle gap between the last vector byte and the first
  // MAC; it clears the datapath so the first result appears N_COLS+1 cycles
  // after the last vector byte.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_V,
    S_START,
    S_COMPUTE,
    S_SEND
  } state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   mat_q [N_ELEM];
  logic signed [DATA_W-1:0]   mat_d [N_ELEM];
  logic signed [DATA_W-1:0]   vec_q [N_COLS];
  logic signed [DATA_W-1:0]   vec_d [N_COLS];
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [ACC_W-1:0]           result_q, result_d;
  logic [EL_W-1:0]            el_q, el_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [BYTE_W-1:0]          byte_q, byte_d;
  logic                       s_ready_q, s_ready_d;
  logic                       m_valid_q, m_valid_d;
  logic [7:0]                 m_data_q, m_data_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;

  logic                       in_fire;
  logic                       out_fire;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]           acc_sum;

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = busy_q;
  assign err     = err_q;

  always_comb begin
    state_d  = state_q;
    mat_d    = mat_q;
    vec_d    = vec_q;
    acc_d    = acc_q;
    result_d = result_q;
    el_d     = el_q;
    col_d    = col_q;
    row_d    = row_q;
    byte_d   = byte_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    err_d     = err_q;

    in_fire  = s_valid & s_ready_q;
    out_fire = m_valid_q & m_ready;

    // During COMPUTE el_q tracks row*N_COLS+col, so it addresses the matrix
    // directly without a multiplier.
    prod     = mat_q[el_q] * vec_q[col_q];
    prod_ext = ACC_W'(prod);
    acc_sum  = acc_q + prod_ext;

    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          case (s_data)
            CMD_LOAD_M: begin
              state_d = S_LOAD_M;
              el_d    = '0;
            end
            CMD_LOAD_V: begin
              state_d = S_LOAD_V;
              col_d   = '0;
            end
            CMD_CLEAR: begin
              for (int i = 0; i < N_ELEM; i++) mat_d[i] = '0;
              err_d = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_LOAD_M: begin
        if (in_fire) begin
          mat_d[el_q] = s_data[DATA_W-1:0];
          if (el_q == EL_W'(N_ELEM - 1)) begin
            el_d    = '0;
            state_d = S_IDLE;
          end else begin
            el_d = el_q + EL_W'(1);
          end
        end
      end

      S_LOAD_V: begin
        if (in_fire) begin
          vec_d[col_q] = s_data[DATA_W-1:0];
          if (col_q == COL_W'(N_COLS - 1)) begin
            col_d   = '0;
            state_d = S_START;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      S_START: begin
        acc_d   = '0;
        row_d   = '0;
        col_d   = '0;
        el_d    = '0;
        state_d = S_COMPUTE;
      end

      S_COMPUTE: begin
        acc_d = acc_sum;
        el_d  = el_q + EL_W'(1);
        if (col_q == COL_W'(N_COLS - 1)) begin
          result_d  = acc_sum;
          col_d     = '0;
          byte_d    = '0;
          m_valid_d = 1'b1;
          m_data_d  = acc_sum[7:0];
          state_d   = S_SEND;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end

      S_SEND: begin
        if (out_fire) begin
          if (byte_q == BYTE_W'(OUT_BYTES - 1)) begin
            m_valid_d = 1'b0;
            byte_d    = '0;
            if (row_q != ROW_W'(N_ROWS - 1)) begin
              row_d   = row_q + ROW_W'(1);
              acc_d   = '0;
              col_d   = '0;
              state_d = S_COMPUTE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            byte_d   = byte_q + BYTE_W'(1);
            m_data_d = 8'(result_q >> (8 * (int'(byte_q) + 1)));
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so they line up with state_q.
    s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_M) ||
                (state_d == S_LOAD_V);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < N_ELEM; i++) mat_q[i] <= '0;
      for (int i = 0; i < N_COLS; i++) vec_q[i] <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      el_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      byte_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mat_q     <= mat_d;
      vec_q     <= vec_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      el_q      <= el_d;
      col_q     <= col_d;
      row_q     <= row_d;
      byte_q    <= byte_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

endmodule
